// File: rtl/alu_stage_unit.sv
// Execute-stage ALU: computes result/flag from regA/regB or the 9-bit immediate, registers write-back control.
// Latency 1 cycle, one op per cycle; no backpressure, enable_alu=0 stalls by holding all outputs.
module alu_stage_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_alu,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    input  logic [3:0]  cop,
    input  logic [2:0]  destReg_addr,
    input  logic        we,
    input  logic [8:0]  inmediate,
    output logic [15:0] alu_result,
    output logic        OVF,
    output logic [2:0]  destReg_addr_output,
    output logic        we_output
);

    localparam logic [3:0] OP_MOVR = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MOVI = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;

    // Bit 16 of the widened add/sub is the unsigned carry-out / borrow.
    logic [16:0] sum_w;
    logic [16:0] diff_w;
    logic [15:0] imm_sext;
    logic [15:0] res_nxt;
    logic        flag_nxt;

    assign sum_w    = {1'b0, regA} + {1'b0, regB};
    assign diff_w   = {1'b0, regA} - {1'b0, regB};
    assign imm_sext = {{7{inmediate[8]}}, inmediate};

    always_comb begin
        res_nxt  = 16'h0000;
        flag_nxt = 1'b0;
        case (cop)
            OP_MOVR: res_nxt = regA;
            OP_ADD: begin
                res_nxt  = sum_w[15:0];
                flag_nxt = sum_w[16];
            end
            OP_SUB: begin
                res_nxt  = diff_w[15:0];
                flag_nxt = diff_w[16];
            end
            OP_MOVI: res_nxt = imm_sext;
            OP_AND:  res_nxt = regA & regB;
            OP_OR:   res_nxt = regA | regB;
            OP_XOR:  res_nxt = regA ^ regB;
            OP_NOT:  res_nxt = ~regA;
            OP_SHL:  res_nxt = regA << inmediate[3:0];
            OP_SHR:  res_nxt = regA >> inmediate[3:0];
            default: begin
                res_nxt  = 16'h0000;
                flag_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result          <= 16'h0000;
            OVF                 <= 1'b0;
            destReg_addr_output <= 3'b000;
            we_output           <= 1'b0;
        end else if (enable_alu) begin
            alu_result          <= res_nxt;
            OVF                 <= flag_nxt;
            destReg_addr_output <= destReg_addr;
            we_output           <= we;
        end
    end

endmodule

// File: tb/tb_alu_stage_unit.sv
// Directed-vector bench for alu_stage_unit with hand-computed expected values.
module tb_alu_stage_unit;

    logic        clk;
    logic        reset;
    logic        enable_alu;
    logic [15:0] regA;
    logic [15:0] regB;
    logic [3:0]  cop;
    logic [2:0]  destReg_addr;
    logic        we;
    logic [8:0]  inmediate;
    logic [15:0] alu_result;
    logic        OVF;
    logic [2:0]  destReg_addr_output;
    logic        we_output;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_stage_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .enable_alu          (enable_alu),
        .regA                (regA),
        .regB                (regB),
        .cop                 (cop),
        .destReg_addr        (destReg_addr),
        .we                  (we),
        .inmediate           (inmediate),
        .alu_result          (alu_result),
        .OVF                 (OVF),
        .destReg_addr_output (destReg_addr_output),
        .we_output           (we_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one enabled operation, clock it, check result and flag.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [8:0] imm,
                          input logic [15:0] exp_r, input logic exp_f);
        cop        = op;
        regA       = a;
        regB       = b;
        inmediate  = imm;
        enable_alu = 1'b1;
        tick();
        check_val({tag, "_res"}, {16'h0, alu_result}, {16'h0, exp_r});
        check_val({tag, "_ovf"}, {31'h0, OVF}, {31'h0, exp_f});
    endtask

    logic [15:0] sweep_exp [7];
    logic        sweep_ovf [7];

    initial begin
        reset        = 1'b0;
        enable_alu   = 1'b1;
        regA         = 16'hA5A5;
        regB         = 16'h5A5A;
        cop          = 4'b0001;
        destReg_addr = 3'b111;
        we           = 1'b1;
        inmediate    = 9'h1FF;

        // Reset held across edges with arbitrary inputs.
        tick();
        tick();
        check_val("rst_res",  {16'h0, alu_result}, 32'h0);
        check_val("rst_ovf",  {31'h0, OVF}, 32'h0);
        check_val("rst_dst",  {29'h0, destReg_addr_output}, 32'h0);
        check_val("rst_we",   {31'h0, we_output}, 32'h0);

        // Release with MOVR of zero; first edge must capture immediately.
        regA         = 16'h0000;
        cop          = 4'b0000;
        destReg_addr = 3'b001;
        we           = 1'b1;
        reset        = 1'b1;
        tick();
        check_val("rel_res", {16'h0, alu_result}, 32'h0);
        check_val("rel_dst", {29'h0, destReg_addr_output}, 32'h1);
        check_val("rel_we",  {31'h0, we_output}, 32'h1);

        run_op("add1", 4'b0001, 16'h0001, 16'h0001, 9'h000, 16'h0002, 1'b0);
        run_op("add2", 4'b0001, 16'h0001, 16'hFFFF, 9'h000, 16'h0000, 1'b1);
        run_op("sub1", 4'b0010, 16'h0001, 16'h0001, 9'h000, 16'h0000, 1'b0);
        run_op("sub2", 4'b0010, 16'h0001, 16'h0002, 9'h000, 16'hFFFF, 1'b1);
        run_op("movi1", 4'b0011, 16'h1234, 16'h0000, 9'h049, 16'h0049, 1'b0);
        run_op("movi2", 4'b0011, 16'h1234, 16'h0000, 9'h1FF, 16'hFFFF, 1'b0);
        run_op("movi3", 4'b0011, 16'h0000, 16'h0000, 9'h100, 16'hFF00, 1'b0);

        // Opcode sweep 0000..0110, one op per cycle.
        sweep_exp = '{16'h00F0, 16'h0FFF, 16'hF1E1, 16'h0049, 16'h0000, 16'h0FFF, 16'h0FFF};
        sweep_ovf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++)
            run_op($sformatf("sweep%0d", i), 4'(i), 16'h00F0, 16'h0F0F, 9'h049,
                   sweep_exp[i], sweep_ovf[i]);

        run_op("not",  4'b0111, 16'h00F0, 16'h0000, 9'h000, 16'hFF0F, 1'b0);
        run_op("shl",  4'b1000, 16'h00F0, 16'h0000, 9'h004, 16'h0F00, 1'b0);
        run_op("shr",  4'b1001, 16'h00F0, 16'h0000, 9'h004, 16'h000F, 1'b0);
        run_op("shlf", 4'b1000, 16'h8001, 16'h0000, 9'h1FF, 16'h8000, 1'b0);
        run_op("shrf", 4'b1001, 16'h8001, 16'h0000, 9'h00F, 16'h0001, 1'b0);
        // Carry into reserved op must clear OVF.
        run_op("add3", 4'b0001, 16'hFFFF, 16'hFFFF, 9'h000, 16'hFFFE, 1'b1);
        run_op("rsv",  4'b1010, 16'hFFFF, 16'hFFFF, 9'h1FF, 16'h0000, 1'b0);
        run_op("rsvf", 4'b1111, 16'h1234, 16'h4321, 9'h0AA, 16'h0000, 1'b0);

        // Pass-through of we/destReg_addr, independent of opcode.
        destReg_addr = 3'b101;
        we           = 1'b0;
        run_op("pt", 4'b0001, 16'hFFFF, 16'h0001, 9'h000, 16'h0000, 1'b1);
        check_val("pt_dst", {29'h0, destReg_addr_output}, 32'h5);
        check_val("pt_we",  {31'h0, we_output}, 32'h0);

        // Stall: inputs change while disabled, outputs must hold.
        enable_alu   = 1'b0;
        cop          = 4'b0101;
        regA         = 16'h1111;
        regB         = 16'h2222;
        destReg_addr = 3'b010;
        we           = 1'b1;
        tick();
        tick();
        check_val("stall_res", {16'h0, alu_result}, 32'h0);
        check_val("stall_ovf", {31'h0, OVF}, 32'h1);
        check_val("stall_dst", {29'h0, destReg_addr_output}, 32'h5);
        check_val("stall_we",  {31'h0, we_output}, 32'h0);

        enable_alu = 1'b1;
        tick();
        check_val("reen_res", {16'h0, alu_result}, 32'h3333);
        check_val("reen_ovf", {31'h0, OVF}, 32'h0);
        check_val("reen_dst", {29'h0, destReg_addr_output}, 32'h2);
        check_val("reen_we",  {31'h0, we_output}, 32'h1);

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("arst_res", {16'h0, alu_result}, 32'h0);
        check_val("arst_dst", {29'h0, destReg_addr_output}, 32'h0);
        check_val("arst_we",  {31'h0, we_output}, 32'h0);
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
